cic_interpolator: RTL and testbench

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

---
 rtl/cic_interpolator_pkg.sv | 17 +
 rtl/cic_integrator.sv | 22 ++
 rtl/cic_interpolator.sv | 111 +++++++++++
 tb/tb_cic_interpolator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_interpolator_pkg.sv
// Shared constants and helpers for the CIC interpolator.
package cic_interpolator_pkg;

    localparam int unsigned RATE_MIN         = 2;
    localparam int unsigned N_STAGES_DEFAULT = 4;
    localparam int unsigned GROWTH_PER_STAGE = 8;

    typedef enum logic {
        SLOT_STUFF  = 1'b0,
        SLOT_SAMPLE = 1'b1
    } slot_t;

    function automatic logic [7:0] clamp_rate(input logic [7:0] rate);
        return (rate < 8'(RATE_MIN)) ? 8'(RATE_MIN) : rate;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// Single registered accumulator with enable and synchronous clear; wraps modulo 2^ACC_WIDTH.
module cic_integrator #(
    parameter int ACC_WIDTH = 48
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [ACC_WIDTH-1:0] d_in,
    output logic [ACC_WIDTH-1:0] d_out
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            d_out <= '0;
        else if (clear)
            d_out <= '0;
        else if (enable)
            d_out <= d_out + d_in;
    end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: inline comb section at the low rate, zero-stuffing, cascaded integrators.
// Define CIC_INTERP_ROUND_EN to round (rather than truncate) at the output scaling stage.
module cic_interpolator
    import cic_interpolator_pkg::*;
#(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int N_STAGES     = N_STAGES_DEFAULT,
    parameter int ACC_WIDTH    = INPUT_WIDTH + GROWTH_PER_STAGE * N_STAGES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              rate,
    input  logic [5:0]              shift,
    input  logic [INPUT_WIDTH-1:0]  d_in,
    output logic                    strobe_in,
    output logic [OUTPUT_WIDTH-1:0] d_out,
    output logic                    strobe_out
);

    logic [7:0]           count;
    slot_t                slot_d;
    logic [ACC_WIDTH-1:0] comb_x   [N_STAGES+1];
    logic [ACC_WIDTH-1:0] comb_dly [N_STAGES];
    logic [ACC_WIDTH-1:0] comb_out;
    logic [ACC_WIDTH-1:0] integ    [N_STAGES+1];
    logic [ACC_WIDTH-1:0] scaled;
    logic [N_STAGES+1:0]  en_pipe;

    // Gated by reset so the request drops immediately on async reset.
    assign strobe_in = reset && enable && (count == '0);

    // Rate is sampled only at reload, so a change never disturbs the current period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (!enable)
            count <= '0;
        else if (count == '0)
            count <= clamp_rate(rate) - 8'd1;
        else
            count <= count - 8'd1;
    end

    always_comb begin
        comb_x[0] = {{(ACC_WIDTH-INPUT_WIDTH){d_in[INPUT_WIDTH-1]}}, d_in};
        for (int unsigned i = 0; i < N_STAGES; i++)
            comb_x[i+1] = comb_x[i] - comb_dly[i];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_STAGES; i++)
                comb_dly[i] <= '0;
            comb_out <= '0;
            slot_d   <= SLOT_STUFF;
        end else if (!enable) begin
            for (int unsigned i = 0; i < N_STAGES; i++)
                comb_dly[i] <= '0;
            comb_out <= '0;
            slot_d   <= SLOT_STUFF;
        end else begin
            slot_d <= strobe_in ? SLOT_SAMPLE : SLOT_STUFF;
            if (strobe_in) begin
                for (int unsigned i = 0; i < N_STAGES; i++)
                    comb_dly[i] <= comb_x[i];
                comb_out <= comb_x[N_STAGES];
            end
        end
    end

    assign integ[0] = (slot_d == SLOT_SAMPLE) ? comb_out : '0;

    for (genvar g = 0; g < N_STAGES; g++) begin : g_integ
        cic_integrator #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_integ (
            .clock (clock),
            .reset (reset),
            .enable(enable),
            .clear (!enable),
            .d_in  (integ[g]),
            .d_out (integ[g+1])
        );
    end

`ifdef CIC_INTERP_ROUND_EN
    logic [ACC_WIDTH-1:0] round_add;
    assign round_add = (shift == '0) ? '0 : (ACC_WIDTH'(1) << (shift - 6'd1));
    assign scaled    = integ[N_STAGES] + round_add;
`else
    assign scaled    = integ[N_STAGES];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_out   <= '0;
            en_pipe <= '0;
        end else if (!enable) begin
            d_out   <= '0;
            en_pipe <= '0;
        end else begin
            d_out   <= OUTPUT_WIDTH'(scaled >> shift);
            en_pipe <= {en_pipe[N_STAGES:0], 1'b1};
        end
    end

    assign strobe_out = en_pipe[N_STAGES+1];

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench: expected outputs come from the closed-form CIC impulse response.
module tb_cic_interpolator;

    localparam int IW  = 16;
    localparam int OW  = 16;
    localparam int NS  = 4;
    localparam int LAT = NS + 2;

    logic          clock  = 1'b0;
    logic          reset  = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    rate   = 8'd4;
    logic [5:0]    shift  = 6'd0;
    logic [IW-1:0] d_in   = '0;
    logic          strobe_in;
    logic          strobe_out;
    logic [OW-1:0] d_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [OW-1:0] d;
        logic          s;
    } exp_t;

    longint h_q[$];

    always #5 clock = ~clock;

    cic_interpolator #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .N_STAGES    (NS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .rate      (rate),
        .shift     (shift),
        .d_in      (d_in),
        .strobe_in (strobe_in),
        .d_out     (d_out),
        .strobe_out(strobe_out)
    );

    // Impulse response = (1 + z^-1 + ... + z^-(R-1))^N
    function automatic void build_h(input int r);
        longint nxt[$];
        h_q.delete();
        h_q.push_back(1);
        for (int s = 0; s < NS; s++) begin
            nxt.delete();
            for (int k = 0; k < h_q.size() + r - 1; k++) nxt.push_back(0);
            for (int i = 0; i < h_q.size(); i++)
                for (int j = 0; j < r; j++) nxt[i+j] += h_q[i];
            h_q = nxt;
        end
    endfunction

    function automatic logic [OW-1:0] scale(input longint acc, input int sh);
        longint v;
        v = acc;
`ifdef CIC_INTERP_ROUND_EN
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
        v = v >>> sh;
        return v[OW-1:0];
    endfunction

    task automatic idle(input int n);
        @(posedge clock); #1;
        enable = 1'b0;
        repeat (n) @(posedge clock);
    endtask

    // mode 0: constant val on every strobe; 1: impulse val then 0; 2: random samples
    task automatic run_stream(input int r, input int sh, input int ncyc, input int mode,
                              input int val, input int abort_at, input string tag);
        longint line [0:1023];
        exp_t   sb[$];
        exp_t   e;
        int     reff;
        logic   exp_s;
        logic [IW-1:0] x;
        reff = (r < 2) ? 2 : r;
        build_h(reff);
        for (int i = 0; i < 1024; i++) line[i] = 0;
        @(posedge clock); #1;
        rate = 8'(r); shift = 6'(sh); reset = 1'b1; enable = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            exp_s = ((c % reff) == 0);
            if (exp_s) begin
                case (mode)
                    0:       x = IW'(val);
                    1:       x = (c == 0) ? IW'(val) : '0;
                    default: x = IW'($urandom_range(0, 2000) - 1000);
                endcase
                for (int j = 0; j < h_q.size(); j++)
                    line[c+LAT+j] += longint'($signed(x)) * h_q[j];
            end else begin
                x = IW'($urandom);
            end
            d_in = x;
            e.d = scale(line[c+LAT], sh);
            e.s = 1'b1;
            sb.push_back(e);
            @(negedge clock);
            total++;
            if (strobe_in !== exp_s) begin
                bad++;
                $display("FAIL %s strobe_in c=%0d got=%b want=%b", tag, c, strobe_in, exp_s);
            end
            if (c >= LAT) begin
                e = sb.pop_front();
                total++;
                if (d_out !== e.d || strobe_out !== e.s) begin
                    bad++;
                    $display("FAIL %s d_out c=%0d got=%0d/%b want=%0d/%b",
                             tag, c, $signed(d_out), strobe_out, $signed(e.d), e.s);
                end
            end else begin
                total++;
                if (d_out !== '0 || strobe_out !== 1'b0) begin
                    bad++;
                    $display("FAIL %s pre_latency c=%0d got=%0d/%b want=0/0",
                             tag, c, $signed(d_out), strobe_out);
                end
            end
            if (c == abort_at) return;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; rate = 8'd4;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if (d_out !== '0 || strobe_in !== 1'b0 || strobe_out !== 1'b0) begin
            bad++;
            $display("FAIL reset got d_out=%0d strobe_in=%b strobe_out=%b want 0/0/0",
                     d_out, strobe_in, strobe_out);
        end
        enable = 1'b0;
        reset  = 1'b1;
        idle(2);
    endtask

    task automatic test_rate_change();
        logic exp_s;
        @(posedge clock); #1;
        rate = 8'd4; enable = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c == 2) rate = 8'd8;
            exp_s = (c == 0) || (c == 4) || (c == 12) || (c == 20);
            @(negedge clock);
            total++;
            if (strobe_in !== exp_s) begin
                bad++;
                $display("FAIL rate_change c=%0d got=%b want=%b", c, strobe_in, exp_s);
            end
            @(posedge clock); #1;
        end
        idle(2);
    endtask

    task automatic test_dc();
        run_stream(4, 6, 40, 0, 100, -1, "dc");
        total++;
        if (d_out !== OW'(100)) begin
            bad++;
            $display("FAIL dc_settle got=%0d want=100", d_out);
        end
        idle(2);
    endtask

    task automatic test_impulse();
        run_stream(4, 0, 30, 1, 1, -1, "impulse");
        idle(2);
    endtask

    task automatic test_rate_low();
        run_stream(0, 0, 16, 1, 5, -1, "rate0");
        idle(2);
        run_stream(1, 0, 16, 0, -7, -1, "rate1");
        idle(2);
    endtask

    task automatic test_random();
        run_stream(3, 2, 50, 2, 0, -1, "random");
        idle(2);
    endtask

    task automatic test_rounding();
        run_stream(2, 1, 14, 1, 3, -1, "round");
        idle(2);
    endtask

    task automatic test_reset_mid();
        run_stream(4, 6, 20, 0, 100, 10, "pre_reset");
        #2 reset = 1'b0;
        #1;
        total++;
        if (d_out !== '0 || strobe_in !== 1'b0 || strobe_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got d_out=%0d strobe_in=%b strobe_out=%b want 0/0/0",
                     d_out, strobe_in, strobe_out);
        end
        @(posedge clock);
        run_stream(4, 6, 40, 0, 100, -1, "post_reset");
        idle(2);
    endtask

    task automatic test_enable_low();
        run_stream(4, 6, 20, 0, 100, -1, "pre_disable");
        @(posedge clock); #1;
        enable = 1'b0;
        @(negedge clock);
        total++;
        if (strobe_in !== 1'b0) begin
            bad++;
            $display("FAIL disable strobe_in got=%b want=0", strobe_in);
        end
        @(posedge clock); #1;
        total++;
        if (d_out !== '0 || strobe_out !== 1'b0) begin
            bad++;
            $display("FAIL disable_clear got d_out=%0d strobe_out=%b want 0/0", d_out, strobe_out);
        end
        run_stream(4, 6, 30, 0, 100, -1, "re_enable");
        idle(2);
    endtask

    initial begin
        test_reset();
        test_rate_change();
        test_dc();
        test_impulse();
        test_rate_low();
        test_random();
        test_rounding();
        test_reset_mid();
        test_enable_low();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
